// File: rtl/reset_sequencer.sv
// SoC reset generator: synchronizes PLL lock and the GRESET button, debounces the button,
// stretches reset after every cause, and reports the last cause and a saturating reset count.
module reset_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int STRETCH_CYCLES  = 255
) (
  input  logic       CLK,
  input  logic       reset_in,
  input  logic       pll_locked,
  input  logic       button,
  output logic       sys_reset,
  output logic [1:0] reset_cause,
  output logic [7:0] rst_count
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SW = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] ST_LAST = SW'(STRETCH_CYCLES - 1);

  localparam logic [1:0] S_WAIT_LOCK = 2'd0;
  localparam logic [1:0] S_STRETCH   = 2'd1;
  localparam logic [1:0] S_RUN       = 2'd2;
  localparam logic [1:0] S_HOLD      = 2'd3;

  localparam logic [1:0] C_POR  = 2'b00;
  localparam logic [1:0] C_LOCK = 2'b01;
  localparam logic [1:0] C_BTN  = 2'b10;

  // Bit 0 carries pll_locked, bit 1 carries button; the last stage feeds all logic.
  logic [SYNC_STAGES-1:0][1:0] sync_q;
  logic                        lock_s, btn_s;

  always_ff @(posedge CLK or posedge reset_in) begin
    if (reset_in) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], {button, pll_locked}};
  end

  assign lock_s = sync_q[SYNC_STAGES-1][0];
  assign btn_s  = sync_q[SYNC_STAGES-1][1];

  logic          btn_db_q, btn_db_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;

  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = '0;
    if (btn_s != btn_db_q) begin
      if (db_cnt_q == DB_LAST) btn_db_d = btn_s;
      else                     db_cnt_d = db_cnt_q + DW'(1);
    end
  end

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] st_cnt_q, st_cnt_d;
  logic [1:0]    cause_q, cause_d;
  logic [7:0]    count_q, count_d;
  logic          count_inc;
  logic          sys_reset_q;

  // Lock loss is checked first in every state so it always wins over the button.
  always_comb begin
    state_d   = state_q;
    st_cnt_d  = st_cnt_q;
    cause_d   = cause_q;
    count_inc = 1'b0;
    case (state_q)
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_d  = S_STRETCH;
          st_cnt_d = '0;
        end
      end
      S_STRETCH: begin
        if (!lock_s)                 state_d = S_WAIT_LOCK;
        else if (btn_db_q)           state_d = S_HOLD;
        else if (st_cnt_q == ST_LAST) state_d = S_RUN;
        else                         st_cnt_d = st_cnt_q + SW'(1);
      end
      S_RUN: begin
        if (!lock_s) begin
          state_d   = S_WAIT_LOCK;
          cause_d   = C_LOCK;
          count_inc = 1'b1;
        end else if (btn_db_q) begin
          state_d   = S_HOLD;
          cause_d   = C_BTN;
          count_inc = 1'b1;
        end
      end
      default: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
          cause_d = C_LOCK;
        end else if (!btn_db_q) begin
          state_d  = S_STRETCH;
          st_cnt_d = '0;
        end
      end
    endcase
    count_d = (count_inc && (count_q != 8'hFF)) ? count_q + 8'd1 : count_q;
  end

  always_ff @(posedge CLK or posedge reset_in) begin
    if (reset_in) begin
      btn_db_q    <= 1'b0;
      db_cnt_q    <= '0;
      state_q     <= S_WAIT_LOCK;
      st_cnt_q    <= '0;
      cause_q     <= C_POR;
      count_q     <= '0;
      sys_reset_q <= 1'b1;
    end else begin
      btn_db_q    <= btn_db_d;
      db_cnt_q    <= db_cnt_d;
      state_q     <= state_d;
      st_cnt_q    <= st_cnt_d;
      cause_q     <= cause_d;
      count_q     <= count_d;
      sys_reset_q <= (state_d != S_RUN);
    end
  end

  assign sys_reset   = sys_reset_q;
  assign reset_cause = cause_q;
  assign rst_count   = count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomized + directed bench for reset_sequencer; a queue/countdown model of the reset
// rules is checked every cycle, with literal edge-count expectations pinning the model.
module tb_reset_sequencer;

  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int ST   = 4;

  logic       CLK = 1'b0;
  logic       reset_in = 1'b1;
  logic       pll_locked = 1'b0;
  logic       button = 1'b0;
  logic       sys_reset;
  logic [1:0] reset_cause;
  logic [7:0] rst_count;

  int n_tests = 0;
  int n_fail  = 0;

  reset_sequencer #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB), .STRETCH_CYCLES(ST)) dut (
    .CLK(CLK), .reset_in(reset_in), .pll_locked(pll_locked), .button(button),
    .sys_reset(sys_reset), .reset_cause(reset_cause), .rst_count(rst_count)
  );

  initial forever #5 CLK = ~CLK;

  task automatic chk(input string nm, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int P_WAIT = 0, P_STR = 1, P_RUN = 2, P_HOLD = 3;
  bit lk_q[$];
  bit bt_q[$];
  int m_phase, m_remain, m_diff, m_cause, m_count;
  bit m_db, m_sys;

  task m_reset();
    lk_q = {};
    bt_q = {};
    repeat (SYNC) begin
      lk_q.push_back(1'b0);
      bt_q.push_back(1'b0);
    end
    m_phase = P_WAIT; m_remain = 0; m_diff = 0; m_db = 0;
    m_cause = 0; m_count = 0; m_sys = 1;
  endtask

  task m_step();
    bit ls, bs;
    ls = lk_q.pop_front();
    bs = bt_q.pop_front();
    lk_q.push_back(pll_locked);
    bt_q.push_back(button);
    case (m_phase)
      P_WAIT: if (ls) begin m_phase = P_STR; m_remain = ST; end
      P_STR: begin
        if (!ls) m_phase = P_WAIT;
        else if (m_db) m_phase = P_HOLD;
        else begin
          m_remain--;
          if (m_remain == 0) m_phase = P_RUN;
        end
      end
      P_RUN: begin
        if (!ls) begin
          m_phase = P_WAIT; m_cause = 1;
          if (m_count < 255) m_count++;
        end else if (m_db) begin
          m_phase = P_HOLD; m_cause = 2;
          if (m_count < 255) m_count++;
        end
      end
      default: begin
        if (!ls) begin m_phase = P_WAIT; m_cause = 1; end
        else if (!m_db) begin m_phase = P_STR; m_remain = ST; end
      end
    endcase
    // button must disagree with the debounced level on DB consecutive edges to flip it
    if (bs == m_db) m_diff = 0;
    else begin
      m_diff++;
      if (m_diff == DB) begin m_db = bs; m_diff = 0; end
    end
    m_sys = (m_phase != P_RUN);
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge CLK or posedge reset_in);
      if (reset_in) m_reset();
      else          m_step();
    end
  end

  initial forever begin
    @(negedge CLK);
    if (!reset_in) begin
      chk("model sys_reset", int'(sys_reset), int'(m_sys));
      chk("model reset_cause", int'(reset_cause), m_cause);
      chk("model rst_count", int'(rst_count), m_count);
    end
  end

  // ---------------- stimulus ----------------
  task automatic nedge(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL timeout: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    nedge(2);
    chk("por sys_reset", int'(sys_reset), 1);
    chk("por cause", int'(reset_cause), 0);
    chk("por count", int'(rst_count), 0);

    // power-up: lock sampled at edge 1, release at edge 7
    reset_in = 1'b0;
    pll_locked = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      nedge(1);
      chk($sformatf("lock-up sys_reset edge%0d", k), int'(sys_reset), int'(k <= 6));
    end
    chk("lock-up cause", int'(reset_cause), 0);
    chk("lock-up count", int'(rst_count), 0);

    // button held 10 cycles from RUN
    button = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      nedge(1);
      chk($sformatf("btn sys_reset edge%0d", k), int'(sys_reset), int'(k >= 7));
    end
    button = 1'b0;
    chk("btn cause", int'(reset_cause), 2);
    chk("btn count", int'(rst_count), 1);
    for (int k = 1; k <= 12; k++) begin
      nedge(1);
      chk($sformatf("btn-rel sys_reset edge%0d", k), int'(sys_reset), int'(k <= 10));
    end

    // short bounces never reach the debounce threshold
    for (int p = 0; p < 4; p++) begin
      button = (p % 2 == 0);
      nedge(2);
    end
    nedge(6);
    chk("bounce sys_reset", int'(sys_reset), 0);
    chk("bounce count", int'(rst_count), 1);

    // lock dropped for 5 cycles
    pll_locked = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      nedge(1);
      chk($sformatf("lockloss sys_reset edge%0d", k), int'(sys_reset), int'(k >= 3));
    end
    pll_locked = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      nedge(1);
      chk($sformatf("relock sys_reset edge%0d", k), int'(sys_reset), int'(k <= 6));
    end
    chk("lockloss cause", int'(reset_cause), 1);
    chk("lockloss count", int'(rst_count), 2);

    // lock loss in the middle of a stretch restarts it and is not counted
    pll_locked = 1'b0;
    nedge(5);
    pll_locked = 1'b1;
    nedge(3);
    pll_locked = 1'b0;
    nedge(6);
    pll_locked = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      nedge(1);
      chk($sformatf("restretch sys_reset edge%0d", k), int'(sys_reset), int'(k <= 6));
    end
    chk("restretch count", int'(rst_count), 3);

    // random traffic on both inputs
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 39) == 0) pll_locked = ~pll_locked;
      if ($urandom_range(0, 5) == 0)  button = ~button;
      nedge(1);
    end
    pll_locked = 1'b1;
    button = 1'b0;
    nedge(20);

    // saturation
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b1;
      nedge(10);
      pll_locked = 1'b0;
      nedge(5);
    end
    chk("saturate count", int'(rst_count), 255);

    // lock loss and debounced button seen on the same edge: lock wins
    pll_locked = 1'b1;
    nedge(10);
    button = 1'b1;
    nedge(4);
    pll_locked = 1'b0;
    nedge(4);
    chk("simul cause", int'(reset_cause), 1);
    chk("simul sys_reset", int'(sys_reset), 1);
    button = 1'b0;
    pll_locked = 1'b1;
    nedge(20);

    // asynchronous reset while holding on the button
    button = 1'b1;
    nedge(9);
    #2 reset_in = 1'b1;
    #1;
    chk("async sys_reset", int'(sys_reset), 1);
    chk("async cause", int'(reset_cause), 0);
    chk("async count", int'(rst_count), 0);
    nedge(1);
    reset_in = 1'b0;
    button = 1'b0;
    nedge(15);
    chk("post-reset sys_reset", int'(sys_reset), 0);
    chk("post-reset count", int'(rst_count), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
